pixel_mem_arbiter: RTL and testbench

Two-port read arbiter that shares the single read port of the image/pixel memory (18-bit address, 24-bit RGB colour word) between the VGA display fetch path and the image-processing path. It sits between the requesters and the color lookup stage that drives the memory. It grants at most one read per cycle, registers the memory address, and tracks each in-flight read through the fixed memory latency. It returns the colour word only to the requester that issued it.

---
 rtl/pixel_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_pixel_mem_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_mem_arbiter.sv
// pixel_mem_arbiter: two-port read arbiter for the pixel memory, display-priority with fixed-latency tagged return.
// Define PIXEL_ARB_STARVE_GUARD_EN to add the starvation guard that forces the processing port through.
module pixel_mem_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 24,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              proc_req,
    input  logic [ADDR_W-1:0] proc_addr,
    output logic              proc_gnt,
    output logic              proc_valid,
    output logic [DATA_W-1:0] proc_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data
);
    typedef enum logic [1:0] {IDLE, DISP, PROC, FORCE} state_t;

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
        $error("pixel_mem_arbiter: MEM_LAT or STARVE_MAX out of range");
    end

    state_t              state_q, state_d;
    logic                force_gnt;
    logic                mem_en_q, mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [MEM_LAT:0]    tag_v_q, tag_v_d;
    logic [MEM_LAT:0]    tag_o_q, tag_o_d;
    logic                disp_valid_q, disp_valid_d;
    logic                proc_valid_q, proc_valid_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic [DATA_W-1:0]   proc_data_q, proc_data_d;
    logic                tail_disp, tail_proc;

`ifdef PIXEL_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    logic [7:0] starve_q, starve_d;

    // One forced grant per saturation; the counter clears on that grant.
    assign force_gnt = proc_req && starve_q == STARVE_LIM && state_q != FORCE;

    always_comb begin
        starve_d = (!proc_req || proc_gnt) ? 8'd0 :
                   (starve_q == STARVE_LIM) ? starve_q : starve_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= 8'd0;
        else        starve_q <= starve_d;
    end
`else
    assign force_gnt = 1'b0;
`endif

    // Grants are masked by reset so every output reads 0 while rst_n is low.
    assign disp_gnt = rst_n && disp_req && !force_gnt;
    assign proc_gnt = rst_n && proc_req && (!disp_req || force_gnt);

    always_comb begin
        state_d = proc_gnt ? (force_gnt ? FORCE : PROC) : disp_gnt ? DISP : state_q;
    end

    always_comb begin
        mem_en_d   = disp_gnt || proc_gnt;
        mem_addr_d = disp_gnt ? disp_addr : proc_gnt ? proc_addr : mem_addr_q;
    end

    // Tag k is valid in the cycle mem_en + k; the tail lines up with mem_data.
    always_comb begin
        tag_v_d = {tag_v_q[MEM_LAT-1:0], mem_en_d};
        tag_o_d = {tag_o_q[MEM_LAT-1:0], proc_gnt};
    end

    assign tail_disp = tag_v_q[MEM_LAT] && !tag_o_q[MEM_LAT];
    assign tail_proc = tag_v_q[MEM_LAT] &&  tag_o_q[MEM_LAT];

    always_comb begin
        disp_valid_d = tail_disp;
        proc_valid_d = tail_proc;
        disp_data_d  = tail_disp ? mem_data : disp_data_q;
        proc_data_d  = tail_proc ? mem_data : proc_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            tag_v_q      <= '0;
            tag_o_q      <= '0;
            disp_valid_q <= 1'b0;
            proc_valid_q <= 1'b0;
            disp_data_q  <= '0;
            proc_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            tag_v_q      <= tag_v_d;
            tag_o_q      <= tag_o_d;
            disp_valid_q <= disp_valid_d;
            proc_valid_q <= proc_valid_d;
            disp_data_q  <= disp_data_d;
            proc_data_q  <= proc_data_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign disp_valid = disp_valid_q;
    assign proc_valid = proc_valid_q;
    assign disp_data  = disp_data_q;
    assign proc_data  = proc_data_q;
endmodule

// File: tb/tb_pixel_mem_arbiter.sv
// tb_pixel_mem_arbiter: directed checks of pixel_mem_arbiter with a 2-cycle memory returning {6'h0, addr}.
module tb_pixel_mem_arbiter;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 24;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              disp_req = 1'b0, proc_req = 1'b0;
    logic [ADDR_W-1:0] disp_addr = '0, proc_addr = '0;
    logic              disp_gnt, proc_gnt, disp_valid, proc_valid, mem_en;
    logic [DATA_W-1:0] disp_data, proc_data, mem_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] m0, m1;
    int                n_chk = 0;
    int                n_fail = 0;
    int                bad;

    pixel_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(2), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .proc_req(proc_req), .proc_addr(proc_addr), .proc_gnt(proc_gnt),
        .proc_valid(proc_valid), .proc_data(proc_data),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_data(mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: data for the address sampled with mem_en is valid MEM_LAT cycles later.
    always @(posedge clk) begin
        m0 <= mem_addr;
        m1 <= m0;
    end
    assign mem_data = {6'h0, m1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic all_zero(input string tag);
        check({tag, " gnt"}, 32'({disp_gnt, proc_gnt}), 32'd0);
        check({tag, " valid"}, 32'({disp_valid, proc_valid}), 32'd0);
        check({tag, " mem_en"}, 32'(mem_en), 32'd0);
        check({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, " disp_data"}, 32'(disp_data), 32'd0);
        check({tag, " proc_data"}, 32'(proc_data), 32'd0);
    endtask

    task automatic drain;
        disp_req = 1'b0;
        proc_req = 1'b0;
        repeat (8) tick();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 all_zero("reset");
        #20 rst_n = 1'b1;
        tick();

        // Single display read: grant in 0, issue in 1, return in 4.
        disp_req = 1'b1; disp_addr = 18'h00ABC;
        @(negedge clk);
        check("single disp_gnt", 32'(disp_gnt), 32'd1);
        check("single proc_gnt", 32'(proc_gnt), 32'd0);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        check("single mem_en", 32'(mem_en), 32'd1);
        check("single mem_addr", 32'(mem_addr), 32'h00ABC);
        for (int c = 2; c <= 6; c++) begin
            tick();
            @(negedge clk);
            check($sformatf("single disp_valid c%0d", c), 32'(disp_valid), 32'(c == 4));
            check($sformatf("single proc_valid c%0d", c), 32'(proc_valid), 32'd0);
            if (c == 4) check("single disp_data", 32'(disp_data), 32'h000ABC);
        end
        tick();

        // Collision: display wins, processing follows next cycle.
        disp_req = 1'b1; disp_addr = 18'd1;
        proc_req = 1'b1; proc_addr = 18'd2;
        @(negedge clk);
        check("coll disp_gnt c0", 32'(disp_gnt), 32'd1);
        check("coll proc_gnt c0", 32'(proc_gnt), 32'd0);
        tick();
        disp_req = 1'b0;
        @(negedge clk);
        check("coll proc_gnt c1", 32'(proc_gnt), 32'd1);
        check("coll disp_gnt c1", 32'(disp_gnt), 32'd0);
        tick();
        proc_req = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            check($sformatf("coll disp_valid c%0d", c), 32'(disp_valid), 32'(c == 4));
            check($sformatf("coll proc_valid c%0d", c), 32'(proc_valid), 32'(c == 5));
            if (c == 4) check("coll disp_data", 32'(disp_data), 32'd1);
            if (c == 5) check("coll proc_data", 32'(proc_data), 32'd2);
            if (c == 5) check("coll disp_data hold", 32'(disp_data), 32'd1);
            tick();
        end

        // Starvation with both ports requesting continuously.
        disp_req = 1'b1; disp_addr = 18'd7;
        proc_req = 1'b1; proc_addr = 18'd9;
`ifdef PIXEL_ARB_STARVE_GUARD_EN
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            check($sformatf("starve proc_gnt c%0d", c), 32'(proc_gnt), 32'(c == 8));
            check($sformatf("starve disp_gnt c%0d", c), 32'(disp_gnt), 32'(c != 8));
            tick();
        end
`else
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (proc_gnt !== 1'b0 || disp_gnt !== 1'b1) bad++;
            tick();
        end
        check("starve no-guard bad cycles", 32'(bad), 32'd0);
`endif
        drain();

        // Streaming: 16 back-to-back display reads return in order, no gaps.
        for (int c = 0; c <= 21; c++) begin
            disp_req = (c < 16);
            disp_addr = 18'(c);
            @(negedge clk);
            if (c < 16) check($sformatf("stream gnt c%0d", c), 32'(disp_gnt), 32'd1);
            check($sformatf("stream valid c%0d", c), 32'(disp_valid), 32'(c >= 4 && c <= 19));
            if (c >= 4 && c <= 19) check($sformatf("stream data c%0d", c), 32'(disp_data), 32'(c - 4));
            check($sformatf("stream proc_valid c%0d", c), 32'(proc_valid), 32'd0);
            tick();
        end
        disp_req = 1'b0;

        // Idle: nothing issued, mem_addr keeps the last streamed address.
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en !== 1'b0 || disp_gnt !== 1'b0 || proc_gnt !== 1'b0 || mem_addr !== 18'd15) bad++;
            tick();
        end
        check("idle bad cycles", 32'(bad), 32'd0);
        check("idle mem_addr", 32'(mem_addr), 32'd15);

        // Reset mid-read: the in-flight display read must never return.
        disp_req = 1'b1; disp_addr = 18'd5;
        @(negedge clk);
        check("rst accept", 32'(disp_gnt), 32'd1);
        tick();
        disp_req = 1'b0;
        tick();
        disp_req = 1'b1; proc_req = 1'b1;
        #1 rst_n = 1'b0;
        #1 all_zero("mid reset");
        tick();
        disp_req = 1'b0; proc_req = 1'b0;
        #2 rst_n = 1'b1;
        bad = 0;
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            if (disp_valid !== 1'b0 || proc_valid !== 1'b0) bad++;
            tick();
        end
        check("post reset stray valid", 32'(bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
